// File: rtl/commutation_pwm.sv
// commutation_pwm: hall-sensor six-step commutation with an edge-aligned PWM carrier.
// Hall inputs are double-synchronized and debounced. Every pattern change is
// preceded by an all-off dead window. Signed step counting and hall error
// detection run alongside. All outputs are registered.
module commutation_pwm #(
    parameter int PERIOD   = 800,
    parameter int DEADTIME = 16,
    parameter int FILTER   = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               hall1,
    input  logic               hall2,
    input  logic               hall3,
    input  logic               enable,
    input  logic signed [15:0] duty,
    output logic [5:0]         PHASES,
    output logic [2:0]         hall_state,
    output logic signed [31:0] comm_count,
    output logic               fault,
    output logic               hall_err
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int FW = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(PERIOD - 1);
    localparam logic [16:0]   MAG_MAX   = 17'(PERIOD);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);
    localparam logic [FW-1:0] FILT_FULL = FW'(FILTER);

    // Position of a hall code in the forward sequence 5,4,6,2,3,1; 7 marks 000/111.
    function automatic logic [2:0] seq_idx(input logic [2:0] code);
        case (code)
            3'd5:    seq_idx = 3'd0;
            3'd4:    seq_idx = 3'd1;
            3'd6:    seq_idx = 3'd2;
            3'd2:    seq_idx = 3'd3;
            3'd3:    seq_idx = 3'd4;
            3'd1:    seq_idx = 3'd5;
            default: seq_idx = 3'd7;
        endcase
    endfunction

    // Next forward position, wrapping 5 back to 0.
    function automatic logic [2:0] seq_succ(input logic [2:0] idx);
        if (idx == 3'd5) begin
            seq_succ = 3'd0;
        end else begin
            seq_succ = idx + 3'd1;
        end
    endfunction

    logic [2:0]         sync1_r, sync2_r, cand_r, hall_state_r;
    logic [FW-1:0]      run_r, run_nxt_s;
    logic               fault_r, hall_err_r, sign_r, en_r;
    logic signed [31:0] comm_count_r, count_nxt_s;
    logic [CW-1:0]      carrier_r, carrier_nxt_s;
    logic [16:0]        mag_r, mag_nxt_s, abs_s, duty_ext_s;
    logic [4:0]         key_r, key_nxt_s;
    logic [DW-1:0]      dead_r, dead_nxt_s;
    logic [5:0]         phases_r, phases_nxt_s;
    logic [2:0]         hall_nxt_s, idx_old_s, idx_new_s;
    logic [2:0]         hi_oh_s, lo_oh_s, hi_sel_s, lo_sel_s;
    logic               fault_nxt_s, err_nxt_s, sign_nxt_s, en_nxt_s;
    logic               accept_s, wrap_s, change_s, chop_s;

    // Next-state logic: hall filter, step bookkeeping, carrier, latches and gate pattern.
    always_comb begin
        run_nxt_s     = run_r;
        hall_nxt_s    = hall_state_r;
        fault_nxt_s   = fault_r;
        count_nxt_s   = comm_count_r;
        err_nxt_s     = 1'b0;
        carrier_nxt_s = carrier_r;
        mag_nxt_s     = mag_r;
        sign_nxt_s    = sign_r;
        en_nxt_s      = en_r;
        dead_nxt_s    = dead_r;
        hi_oh_s       = 3'b000;
        lo_oh_s       = 3'b000;
        hi_sel_s      = 3'b000;
        lo_sel_s      = 3'b000;
        phases_nxt_s  = 6'd0;
        idx_old_s     = seq_idx(hall_state_r);
        idx_new_s     = seq_idx(sync2_r);
        duty_ext_s    = {duty[15], duty};
        abs_s         = 17'd0;

        // A code is accepted once it has been seen on FILTER consecutive cycles.
        if (sync2_r == cand_r) begin
            if (run_r < FILT_FULL) begin
                run_nxt_s = run_r + FW'(1);
            end else begin
                run_nxt_s = run_r;
            end
        end else begin
            run_nxt_s = FW'(1);
        end
        accept_s = (run_nxt_s == FILT_FULL) && (sync2_r != hall_state_r);

        if (accept_s) begin
            hall_nxt_s  = sync2_r;
            fault_nxt_s = (idx_new_s == 3'd7);
            if ((idx_old_s == 3'd7) || (idx_new_s == 3'd7)) begin
                err_nxt_s = 1'b1;
            end else if (idx_new_s == seq_succ(idx_old_s)) begin
                count_nxt_s = comm_count_r + 32'sd1;
            end else if (idx_old_s == seq_succ(idx_new_s)) begin
                count_nxt_s = comm_count_r - 32'sd1;
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            hall_nxt_s  = hall_state_r;
            fault_nxt_s = fault_r;
        end

        // Carrier wraps at PERIOD-1; the drive command is sampled only at the wrap.
        wrap_s = (carrier_r == CAR_LAST);
        if (duty[15]) begin
            abs_s = 17'd0 - duty_ext_s;
        end else begin
            abs_s = duty_ext_s;
        end
        if (wrap_s) begin
            carrier_nxt_s = {CW{1'b0}};
            mag_nxt_s     = (abs_s > MAG_MAX) ? MAG_MAX : abs_s;
            sign_nxt_s    = duty[15];
            en_nxt_s      = enable;
        end else begin
            carrier_nxt_s = carrier_r + CW'(1);
        end

        // Any change of code, direction or enable opens a fresh dead window.
        key_nxt_s = {hall_nxt_s, sign_nxt_s, en_nxt_s};
        change_s  = (key_nxt_s != key_r);
        if (change_s) begin
            dead_nxt_s = DEAD_LOAD;
        end else if (dead_r != {DW{1'b0}}) begin
            dead_nxt_s = dead_r - DW'(1);
        end else begin
            dead_nxt_s = dead_r;
        end

        // Forward commutation table as one-hot phase selects (bit0 = A).
        case (hall_nxt_s)
            3'd5:    begin hi_oh_s = 3'b001; lo_oh_s = 3'b010; end
            3'd4:    begin hi_oh_s = 3'b001; lo_oh_s = 3'b100; end
            3'd6:    begin hi_oh_s = 3'b010; lo_oh_s = 3'b100; end
            3'd2:    begin hi_oh_s = 3'b010; lo_oh_s = 3'b001; end
            3'd3:    begin hi_oh_s = 3'b100; lo_oh_s = 3'b001; end
            3'd1:    begin hi_oh_s = 3'b100; lo_oh_s = 3'b010; end
            default: begin hi_oh_s = 3'b000; lo_oh_s = 3'b000; end
        endcase
        if (sign_nxt_s) begin
            hi_sel_s = lo_oh_s;
            lo_sel_s = hi_oh_s;
        end else begin
            hi_sel_s = hi_oh_s;
            lo_sel_s = lo_oh_s;
        end

        // PHASES is computed from post-edge state so it lines up with the carrier.
        chop_s = (17'(carrier_nxt_s) < mag_nxt_s);
        if (change_s || (dead_r != {DW{1'b0}}) || !en_nxt_s ||
            (mag_nxt_s == 17'd0) || fault_nxt_s) begin
            phases_nxt_s = 6'd0;
        end else begin
            phases_nxt_s = {lo_sel_s, hi_sel_s & {3{chop_s}}};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_r      <= 3'd0;
            sync2_r      <= 3'd0;
            cand_r       <= 3'd0;
            run_r        <= {FW{1'b0}};
            hall_state_r <= 3'd0;
            fault_r      <= 1'b1;
            comm_count_r <= 32'sd0;
            hall_err_r   <= 1'b0;
            carrier_r    <= {CW{1'b0}};
            mag_r        <= 17'd0;
            sign_r       <= 1'b0;
            en_r         <= 1'b0;
            key_r        <= 5'd0;
            dead_r       <= {DW{1'b0}};
            phases_r     <= 6'd0;
        end else begin
            sync1_r      <= {hall3, hall2, hall1};
            sync2_r      <= sync1_r;
            cand_r       <= sync2_r;
            run_r        <= run_nxt_s;
            hall_state_r <= hall_nxt_s;
            fault_r      <= fault_nxt_s;
            comm_count_r <= count_nxt_s;
            hall_err_r   <= err_nxt_s;
            carrier_r    <= carrier_nxt_s;
            mag_r        <= mag_nxt_s;
            sign_r       <= sign_nxt_s;
            en_r         <= en_nxt_s;
            key_r        <= key_nxt_s;
            dead_r       <= dead_nxt_s;
            phases_r     <= phases_nxt_s;
        end
    end

    assign PHASES     = phases_r;
    assign hall_state = hall_state_r;
    assign comm_count = comm_count_r;
    assign fault      = fault_r;
    assign hall_err   = hall_err_r;

endmodule
